timer_scheduler: RTL

Shares one prescaled timebase and one down-counter among several requesters (keypad debounce, wrong-code lockout, display refresh) in the digital-lock design. It sits beside the top-level FSM and derives a 1 MHz tick from the 100 MHz board clock. It grants the timer to one requester at a time in round-robin order and pulses a per-requester `done` when that requester's programmed delay expires.

---
 rtl/timer_sched_pkg.sv | 24 ++
 rtl/tick_gen.sv | 37 +++
 rtl/timer_scheduler.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/timer_sched_pkg.sv
// -----------------------------------------------------------------------------
// timer_sched_pkg
//   Shared definitions for the timer scheduler: FSM state encoding, default
//   build parameters and the prescaler divide-ratio helper.
// -----------------------------------------------------------------------------
package timer_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int CNT_W_DEFAULT   = 16;
  localparam int CLK_HZ_DEFAULT  = 100_000_000;
  localparam int TICK_HZ_DEFAULT = 1_000_000;

  // Clock cycles per tick. The ratio must be an integer >= 2.
  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
//   Free-running prescaler. A counter runs 0..DIV-1 and wraps; tick_out is a
//   registered one-cycle pulse in the cycle after the counter sits at DIV-1,
//   so it fires once every DIV cycles. Nothing ever restarts it.
//
// Ports
//   clk_in   in  1  system clock
//   reset_n  in  1  asynchronous active-low reset
//   tick_out out 1  one-cycle pulse every DIV cycles
// -----------------------------------------------------------------------------
module tick_gen #(
  parameter int DIV = 100
) (
  input  logic clk_in,
  input  logic reset_n,
  output logic tick_out
);

  localparam int            PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] pcnt;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, exactly as the hardware will.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      pcnt     <= '0;
      tick_out <= 1'b0;
    end else begin
      tick_out <= (pcnt == LAST);
      pcnt     <= (pcnt == LAST) ? '0 : pcnt + 1'b1;
    end
  end

endmodule

// File: rtl/timer_scheduler.sv
// -----------------------------------------------------------------------------
// timer_scheduler
//   Shares one prescaled timebase and one down-counter among NREQ requesters.
//   A round-robin arbiter picks the next requester when idle; the owner's
//   delay (in ticks) is latched and counted down on tick_out, and a one-cycle
//   done pulse is issued to that owner on expiry. Dropping req aborts the
//   timing without a done. All outputs come straight from flops.
//
// Ports
//   clk_in   in  1            system clock (only clock)
//   reset_n  in  1            asynchronous active-low reset
//   req      in  NREQ         per-requester request level
//   len      in  NREQ*CNT_W   per-requester delay in ticks, slice i = req i
//   grant    out NREQ         one-hot level for the current owner
//   done     out NREQ         one-hot one-cycle pulse on expiry
//   busy     out 1            high whenever the FSM is not idle
//   tick_out out 1            free-running one-cycle pulse every DIV cycles
// -----------------------------------------------------------------------------
module timer_scheduler
  import timer_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int CNT_W   = CNT_W_DEFAULT,
  parameter int CLK_HZ  = CLK_HZ_DEFAULT,
  parameter int TICK_HZ = TICK_HZ_DEFAULT
) (
  input  logic                  clk_in,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*CNT_W-1:0] len,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic                  tick_out
);

  localparam int DIV   = calc_div(CLK_HZ, TICK_HZ);
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef logic [IDX_W-1:0] idx_t;

  state_t           state, state_nx;
  idx_t             idx, idx_nx;
  idx_t             rr, rr_nx;
  logic [CNT_W-1:0] remain, remain_nx;
  logic [NREQ-1:0]  grant_nx, done_nx;
  logic             tick;
  logic             found;
  idx_t             winner, cand;

  // Index after i, wrapping at NREQ (NREQ need not be a power of two).
  function automatic idx_t wrap_inc(input idx_t i);
    return (int'(i) == NREQ - 1) ? '0 : i + 1'b1;
  endfunction

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk_in   (clk_in),
    .reset_n  (reset_n),
    .tick_out (tick)
  );

  assign tick_out = tick;

  // Round-robin pick: first asserted req scanning upward from rr, wrapping.
  // NOTE: every variable written here gets a default before any branch, so
  // no path leaves a value "held" and no latch is inferred.
  always_comb begin
    found  = 1'b0;
    winner = rr;
    cand   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = idx_t'((int'(rr) + k) % NREQ);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Next-state logic. A dropped req in LOAD/RUN takes priority over expiry,
  // so an abort never produces done; rr still moves past the aborted index.
  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    rr_nx     = rr;
    remain_nx = remain;

    case (state)
      IDLE: begin
        if (found) begin
          idx_nx    = winner;
          remain_nx = len[int'(winner)*CNT_W +: CNT_W];
          state_nx  = LOAD;
        end
      end

      LOAD: begin
        if (!req[idx]) begin
          rr_nx    = wrap_inc(idx);
          state_nx = IDLE;
        end else if (remain == '0) begin
          state_nx = DONE;
        end else begin
          state_nx = RUN;
        end
      end

      RUN: begin
        if (!req[idx]) begin
          rr_nx    = wrap_inc(idx);
          state_nx = IDLE;
        end else if (tick) begin
          // remain stops at 1: the last tick moves to DONE instead.
          if (remain == CNT_W'(1)) state_nx = DONE;
          else                     remain_nx = remain - 1'b1;
        end
      end

      DONE: begin
        rr_nx    = wrap_inc(idx);
        state_nx = IDLE;
      end

      default: state_nx = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they can be registered
  // alongside it and still line up with the state they describe.
  always_comb begin
    grant_nx = '0;
    done_nx  = '0;
    if (state_nx != IDLE) grant_nx[idx_nx] = 1'b1;
    if (state_nx == DONE) done_nx[idx_nx]  = 1'b1;
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      idx    <= '0;
      rr     <= '0;
      remain <= '0;
      grant  <= '0;
      done   <= '0;
      busy   <= 1'b0;
    end else begin
      state  <= state_nx;
      idx    <= idx_nx;
      rr     <= rr_nx;
      remain <= remain_nx;
      grant  <= grant_nx;
      done   <= done_nx;
      busy   <= (state_nx != IDLE);
    end
  end

endmodule
